// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-channel cache-line memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic ARB_RR    = 1'b1;
   localparam logic ARB_FIXED = 1'b0;

   function automatic int idx_w(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner search: first pending channel at or after a start index,
// wrapping modulo NUM_CH; the start index is forced to 0 in fixed-priority mode.
module arb_picker
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int IDX_W  = 1
) (
   input  logic [NUM_CH-1:0] pending_i,
   input  logic [IDX_W-1:0]  pointer_i,
   input  logic              mode_i,
   output logic              valid_o,
   output logic [IDX_W-1:0]  winner_o
);

   logic [IDX_W-1:0] base_s;
   logic [IDX_W-1:0] cand_s;
   logic             hit_s;
   logic             found_s;

   // Scan NUM_CH candidates starting at base_s and keep the first pending one.
   always_comb begin
      base_s   = (mode_i == ARB_RR) ? pointer_i : {IDX_W{1'b0}};
      cand_s   = {IDX_W{1'b0}};
      hit_s    = 1'b0;
      found_s  = 1'b0;
      winner_o = {IDX_W{1'b0}};
      for (int k = 0; k < NUM_CH; k++) begin
         cand_s   = IDX_W'((int'(base_s) + k) % NUM_CH);
         hit_s    = ~found_s & pending_i[cand_s];
         winner_o = hit_s ? cand_s : winner_o;
         found_s  = found_s | hit_s;
      end
      valid_o = |pending_i;
   end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter funnelling cache-line requests onto a single burst memory port.
// One transaction at a time: IDLE grants, BUSY waits for memory, RESP pulses ch_resp.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int RR_MODE = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              ch_read,
   input  logic [NUM_CH-1:0]              ch_write,
   input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_address,
   input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
   output logic [DATA_W-1:0]              ch_rdata,
   output logic [NUM_CH-1:0]              ch_resp,
   output logic                           mem_read,
   output logic                           mem_write,
   output logic [ADDR_W-1:0]              mem_address,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   input  logic                           mem_resp,
   output logic                           busy,
   output logic [idx_w(NUM_CH)-1:0]       grant_idx
);

   localparam int               IDX_W    = idx_w(NUM_CH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic             MODE     = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  grant_q, grant_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [NUM_CH-1:0] resp_q, resp_d;
   logic              busy_q, busy_d;

   logic [NUM_CH-1:0] pending_s;
   logic              pick_valid_s;
   logic [IDX_W-1:0]  pick_idx_s;

   assign pending_s = ch_read | ch_write;

   arb_picker #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_picker (
      .pending_i (pending_s),
      .pointer_i (ptr_q),
      .mode_i    (MODE),
      .valid_o   (pick_valid_s),
      .winner_o  (pick_idx_s)
   );

   // Next-state and next-output logic for the grant / wait / respond sequence.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      resp_d      = {NUM_CH{1'b0}};
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               state_d     = BUSY;
               grant_d     = pick_idx_s;
               // A simultaneous read+write is treated as a write.
               mem_write_d = ch_write[pick_idx_s];
               mem_read_d  = ch_read[pick_idx_s] & ~ch_write[pick_idx_s];
               mem_addr_d  = ch_address[pick_idx_s];
               mem_wdata_d = ch_wdata[pick_idx_s];
               if (MODE == ARB_RR) begin
                  ptr_d = (pick_idx_s == LAST_IDX) ? {IDX_W{1'b0}} : pick_idx_s + IDX_W'(1);
               end else begin
                  ptr_d = ptr_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (mem_resp) begin
               state_d         = RESP;
               mem_read_d      = 1'b0;
               mem_write_d     = 1'b0;
               resp_d[grant_q] = 1'b1;
               if (mem_read_q) begin
                  rdata_d = mem_rdata;
               end else begin
                  rdata_d = rdata_q;
               end
            end else begin
               state_d = BUSY;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= {IDX_W{1'b0}};
         grant_q     <= {IDX_W{1'b0}};
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         rdata_q     <= {DATA_W{1'b0}};
         resp_q      <= {NUM_CH{1'b0}};
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         resp_q      <= resp_d;
         busy_q      <= busy_d;
      end
   end

   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_address = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign ch_rdata    = rdata_q;
   assign ch_resp     = resp_q;
   assign busy        = busy_q;
   assign grant_idx   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: a round-robin and a fixed-priority arbiter (4 channels each)
// driven by channel/memory agents and compared every cycle with a transaction model.
module tb_mem_arbiter;

   localparam int NCH = 4;
   localparam int AW  = 32;
   localparam int DW  = 64;

   logic clk = 1'b0;
   logic rst;

   logic [NCH-1:0]         ch_read_s  [2];
   logic [NCH-1:0]         ch_write_s [2];
   logic [NCH-1:0][AW-1:0] ch_addr_s  [2];
   logic [NCH-1:0][DW-1:0] ch_wdata_s [2];
   logic                   mem_resp_s [2];
   logic [DW-1:0]          mem_rdata_s[2];

   logic [DW-1:0]  ch_rdata_w  [2];
   logic [NCH-1:0] ch_resp_w   [2];
   logic           mem_read_w  [2];
   logic           mem_write_w [2];
   logic [AW-1:0]  mem_addr_w  [2];
   logic [DW-1:0]  mem_wdata_w [2];
   logic           busy_w      [2];
   logic [1:0]     grant_w     [2];

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) u_rr (
      .clk(clk), .rst(rst),
      .ch_read(ch_read_s[0]), .ch_write(ch_write_s[0]),
      .ch_address(ch_addr_s[0]), .ch_wdata(ch_wdata_s[0]),
      .ch_rdata(ch_rdata_w[0]), .ch_resp(ch_resp_w[0]),
      .mem_read(mem_read_w[0]), .mem_write(mem_write_w[0]),
      .mem_address(mem_addr_w[0]), .mem_wdata(mem_wdata_w[0]),
      .mem_rdata(mem_rdata_s[0]), .mem_resp(mem_resp_s[0]),
      .busy(busy_w[0]), .grant_idx(grant_w[0])
   );

   mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) u_fx (
      .clk(clk), .rst(rst),
      .ch_read(ch_read_s[1]), .ch_write(ch_write_s[1]),
      .ch_address(ch_addr_s[1]), .ch_wdata(ch_wdata_s[1]),
      .ch_rdata(ch_rdata_w[1]), .ch_resp(ch_resp_w[1]),
      .mem_read(mem_read_w[1]), .mem_write(mem_write_w[1]),
      .mem_address(mem_addr_w[1]), .mem_wdata(mem_wdata_w[1]),
      .mem_rdata(mem_rdata_s[1]), .mem_resp(mem_resp_s[1]),
      .busy(busy_w[1]), .grant_idx(grant_w[1])
   );

   // Transaction-level reference state, one set per DUT (0 = round-robin, 1 = fixed).
   int             m_owner [2];
   int             m_ptr   [2];
   int             m_grant [2];
   bit             m_inresp[2];
   bit             m_wr    [2];
   logic [AW-1:0]  m_addr  [2];
   logic [DW-1:0]  m_wdata [2];
   logic [DW-1:0]  m_rdata [2];
   logic [NCH-1:0] m_resp  [2];
   bit             rr_mode [2];

   int             mcnt[2];
   int             lat_lo, lat_hi, arm_pct, cyc;
   bit             mem_fix, noise;
   logic [DW-1:0]  mem_fix_data;
   logic [NCH-1:0] arm_mask;

   int n_checks = 0;
   int n_errors = 0;
   int glog_rr[$];
   int glog_fx[$];
   int gcyc_rr[$];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int first_set(input logic [NCH-1:0] v);
      int r;
      r = -1;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (v[i]) r = i;
      end
      return r;
   endfunction

   task automatic model_reset(input int d);
      m_owner[d]  = -1;
      m_ptr[d]    = 0;
      m_grant[d]  = 0;
      m_inresp[d] = 1'b0;
      m_wr[d]     = 1'b0;
      m_addr[d]   = '0;
      m_wdata[d]  = '0;
      m_rdata[d]  = '0;
      m_resp[d]   = '0;
   endtask

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic model_edge(input int d);
      logic [NCH-1:0] pend;
      int w, c, base;
      m_resp[d] = '0;
      if (!rst) begin
         model_reset(d);
      end else if (m_inresp[d]) begin
         m_inresp[d] = 1'b0;
      end else if (m_owner[d] < 0) begin
         pend = ch_read_s[d] | ch_write_s[d];
         if (pend != '0) begin
            w = -1;
            base = rr_mode[d] ? m_ptr[d] : 0;
            for (int k = 0; k < NCH; k++) begin
               c = (base + k) % NCH;
               if (w < 0 && pend[c]) w = c;
            end
            m_owner[d] = w;
            m_grant[d] = w;
            m_wr[d]    = ch_write_s[d][w];
            m_addr[d]  = ch_addr_s[d][w];
            m_wdata[d] = ch_wdata_s[d][w];
            if (rr_mode[d]) m_ptr[d] = (w + 1) % NCH;
         end
      end else if (mem_resp_s[d]) begin
         if (!m_wr[d]) m_rdata[d] = mem_rdata_s[d];
         m_resp[d][m_owner[d]] = 1'b1;
         m_owner[d]  = -1;
         m_inresp[d] = 1'b1;
      end
   endtask

   task automatic compare(input int d);
      string p;
      p = (d == 0) ? "rr" : "fx";
      check_eq({p, " mem_read"},  64'(mem_read_w[d]),  64'((m_owner[d] >= 0) && !m_wr[d]));
      check_eq({p, " mem_write"}, 64'(mem_write_w[d]), 64'((m_owner[d] >= 0) && m_wr[d]));
      check_eq({p, " mem_address"}, 64'(mem_addr_w[d]), 64'(m_addr[d]));
      check_eq({p, " mem_wdata"}, mem_wdata_w[d], m_wdata[d]);
      check_eq({p, " ch_rdata"},  ch_rdata_w[d], m_rdata[d]);
      check_eq({p, " ch_resp"},   64'(ch_resp_w[d]), 64'(m_resp[d]));
      check_eq({p, " busy"},      64'(busy_w[d]), 64'((m_owner[d] >= 0) || m_inresp[d]));
      check_eq({p, " grant_idx"}, 64'(grant_w[d]), 64'(m_grant[d]));
   endtask

   task automatic arm(input int d, input int i);
      int r;
      r = $urandom_range(9, 0);
      ch_write_s[d][i] = (r <= 4);
      ch_read_s[d][i]  = (r == 0) || (r >= 5);
      ch_addr_s[d][i]  = $urandom;
      ch_wdata_s[d][i] = {$urandom, $urandom};
   endtask

   // Channel agents drop on ch_resp and may re-request; memory answers after a latency.
   task automatic drive_agents(input int d);
      mem_resp_s[d] = 1'b0;
      if (mem_read_w[d] || mem_write_w[d]) begin
         if (mcnt[d] < 0) mcnt[d] = $urandom_range(lat_hi, lat_lo);
         if (mcnt[d] == 0) begin
            mem_resp_s[d]  = 1'b1;
            mem_rdata_s[d] = mem_fix ? mem_fix_data : {$urandom, $urandom};
            mcnt[d] = -1;
         end else begin
            mcnt[d]--;
         end
      end else begin
         mcnt[d] = -1;
         mem_resp_s[d]  = noise && ($urandom_range(3, 0) == 0);
         mem_rdata_s[d] = {$urandom, $urandom};
      end
      for (int i = 0; i < NCH; i++) begin
         if (ch_resp_w[d][i]) begin
            ch_read_s[d][i]  = 1'b0;
            ch_write_s[d][i] = 1'b0;
         end else if (!(ch_read_s[d][i] || ch_write_s[d][i]) && arm_mask[i]
                      && ($urandom_range(99, 0) < arm_pct)) begin
            arm(d, i);
         end
      end
   endtask

   task automatic clear_agents();
      for (int d = 0; d < 2; d++) begin
         ch_read_s[d]   = '0;
         ch_write_s[d]  = '0;
         ch_addr_s[d]   = '0;
         ch_wdata_s[d]  = '0;
         mem_resp_s[d]  = 1'b0;
         mem_rdata_s[d] = '0;
         mcnt[d]        = -1;
      end
   endtask

   task automatic step();
      for (int d = 0; d < 2; d++) model_edge(d);
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) compare(d);
      if (ch_resp_w[0] != '0) begin
         glog_rr.push_back(first_set(ch_resp_w[0]));
         gcyc_rr.push_back(cyc);
      end
      if (ch_resp_w[1] != '0) glog_fx.push_back(first_set(ch_resp_w[1]));
      for (int d = 0; d < 2; d++) drive_agents(d);
   endtask

   task automatic run_until_resp(input string tag);
      for (int k = 0; k < 20; k++) begin
         step();
         if (ch_resp_w[0] != '0) break;
      end
      check_eq({tag, " resp seen"}, 64'(ch_resp_w[0] != '0), 64'(1));
   endtask

   task automatic do_reset();
      arm_pct = 0;
      rst = 1'b0;
      clear_agents();
      step();
      step();
      rst = 1'b1;
      glog_rr.delete();
      glog_fx.delete();
      gcyc_rr.delete();
   endtask

   task automatic check_all_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("%s d%0d mem_read", tag, d),    64'(mem_read_w[d]), 64'(0));
         check_eq($sformatf("%s d%0d mem_write", tag, d),   64'(mem_write_w[d]), 64'(0));
         check_eq($sformatf("%s d%0d mem_address", tag, d), 64'(mem_addr_w[d]), 64'(0));
         check_eq($sformatf("%s d%0d mem_wdata", tag, d),   mem_wdata_w[d], 64'(0));
         check_eq($sformatf("%s d%0d ch_rdata", tag, d),    ch_rdata_w[d], 64'(0));
         check_eq($sformatf("%s d%0d ch_resp", tag, d),     64'(ch_resp_w[d]), 64'(0));
         check_eq($sformatf("%s d%0d busy", tag, d),        64'(busy_w[d]), 64'(0));
         check_eq($sformatf("%s d%0d grant_idx", tag, d),   64'(grant_w[d]), 64'(0));
      end
   endtask

   initial begin
      rst = 1'b0;
      rr_mode[0] = 1'b1;
      rr_mode[1] = 1'b0;
      cyc = 0; lat_lo = 0; lat_hi = 0; arm_pct = 0;
      mem_fix = 1'b0; noise = 1'b0; mem_fix_data = '0; arm_mask = '0;
      clear_agents();
      for (int d = 0; d < 2; d++) model_reset(d);
      step();
      step();
      check_all_zero("reset");
      rst = 1'b1;

      // Single read on channel 1, memory answers after several cycles.
      mem_fix = 1'b1; mem_fix_data = 64'hDEAD_BEEF_0123_4567; lat_lo = 4; lat_hi = 4;
      for (int d = 0; d < 2; d++) begin
         ch_read_s[d][1] = 1'b1;
         ch_addr_s[d][1] = 32'h0000_1040;
      end
      step();
      check_eq("read strobe t+1", 64'(mem_read_w[0]), 64'(1));
      check_eq("read address",    64'(mem_addr_w[0]), 64'(32'h0000_1040));
      run_until_resp("read");
      check_eq("read ch_rdata", ch_rdata_w[0], 64'hDEAD_BEEF_0123_4567);
      check_eq("read ch_resp",  64'(ch_resp_w[0]), 64'(4'b0010));
      step();
      check_eq("read resp one cycle", 64'(ch_resp_w[0]), 64'(0));

      // Single write on channel 0; read data must stay untouched.
      lat_lo = 1; lat_hi = 1;
      for (int d = 0; d < 2; d++) begin
         ch_write_s[d][0] = 1'b1;
         ch_addr_s[d][0]  = 32'h0000_2000;
         ch_wdata_s[d][0] = 64'h1122_3344_5566_7788;
      end
      step();
      check_eq("write strobe", 64'(mem_write_w[0]), 64'(1));
      check_eq("write no read", 64'(mem_read_w[0]), 64'(0));
      check_eq("write data", mem_wdata_w[0], 64'h1122_3344_5566_7788);
      run_until_resp("write");
      check_eq("write ch_resp", 64'(ch_resp_w[0]), 64'(4'b0001));
      check_eq("write keeps rdata", ch_rdata_w[0], 64'hDEAD_BEEF_0123_4567);
      step();

      // Illegal read+write on channel 1 is serviced as a write.
      lat_lo = 0; lat_hi = 0;
      for (int d = 0; d < 2; d++) begin
         ch_read_s[d][1]  = 1'b1;
         ch_write_s[d][1] = 1'b1;
         ch_addr_s[d][1]  = 32'h0000_3000;
      end
      step();
      check_eq("rw as write", 64'(mem_write_w[0]), 64'(1));
      check_eq("rw no read",  64'(mem_read_w[0]), 64'(0));
      run_until_resp("rw");
      check_eq("rw ch_resp", 64'(ch_resp_w[0]), 64'(4'b0010));
      step();
      check_eq("rw single pulse", 64'(ch_resp_w[0]), 64'(0));

      // Channels 0 and 2 requesting continuously with single-cycle memory.
      mem_fix = 1'b0;
      do_reset();
      for (int d = 0; d < 2; d++) begin arm(d, 0); arm(d, 2); end
      arm_mask = 4'b0101; arm_pct = 100;
      repeat (14) step();
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("rr 0/2 order %0d", k),
                  64'((k < glog_rr.size()) ? glog_rr[k] : -1), 64'((k % 2) * 2));
         check_eq($sformatf("fx 0/2 order %0d", k),
                  64'((k < glog_fx.size()) ? glog_fx[k] : -1), 64'(0));
      end
      arm_mask = 4'b0100;
      repeat (12) step();
      check_eq("fx ch2 after ch0 drops",
               64'((glog_fx.size() > 0) ? glog_fx[glog_fx.size() - 1] : -1), 64'(2));

      // All four channels requesting continuously.
      do_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < NCH; i++) arm(d, i);
      end
      arm_mask = 4'b1111; arm_pct = 100;
      repeat (16) step();
      for (int k = 0; k < 5; k++) begin
         check_eq($sformatf("rr all order %0d", k),
                  64'((k < glog_rr.size()) ? glog_rr[k] : -1), 64'(k % 4));
         check_eq($sformatf("fx all order %0d", k),
                  64'((k < glog_fx.size()) ? glog_fx[k] : -1), 64'(0));
      end
      for (int k = 1; k < 5; k++) begin
         check_eq($sformatf("rr spacing %0d", k),
                  64'((k < gcyc_rr.size()) ? gcyc_rr[k] - gcyc_rr[k-1] : -1), 64'(3));
      end

      // Reset asserted mid-transaction, then pointer must restart at 0.
      arm_pct = 0; lat_lo = 6; lat_hi = 6;
      repeat (4) step();
      clear_agents();
      repeat (3) step();
      for (int d = 0; d < 2; d++) begin
         ch_read_s[d][2] = 1'b1;
         ch_addr_s[d][2] = $urandom;
      end
      for (int k = 0; k < 10; k++) begin
         step();
         if (m_owner[0] >= 0) break;
      end
      check_eq("busy before reset", 64'(busy_w[0]), 64'(1));
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("async reset");
      for (int d = 0; d < 2; d++) model_reset(d);
      clear_agents();
      step();
      rst = 1'b1;
      lat_lo = 0; lat_hi = 0;
      for (int d = 0; d < 2; d++) begin
         ch_read_s[d][1] = 1'b1;
         ch_read_s[d][3] = 1'b1;
      end
      step();
      check_eq("rr grant after reset", 64'(grant_w[0]), 64'(1));
      check_eq("fx grant after reset", 64'(grant_w[1]), 64'(1));

      // Random traffic with variable latency and stray mem_resp outside BUSY.
      arm_mask = 4'b1111; arm_pct = 30; lat_lo = 0; lat_hi = 3; noise = 1'b1;
      repeat (2000) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- N-channel arbiter that multiplexes cache-line requests onto one burst memory port.
- Successor to the fixed two-cache (I-cache/D-cache) hookup between the cache hierarchy and physical memory.
- Generalised in channel count, address width and data width; selectable round-robin or fixed-priority arbitration.
- Sits between cache_top-style line caches (one per channel) and the top-level memory interface.

Parameters:
NUM_CH, 2, number of requesting channels (>=1)
ADDR_W, 32, address width
DATA_W, 64, memory data width
RR_MODE, 1, 1 = round-robin, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
ch_read  in  NUM_CH  per-channel read request
ch_write  in  NUM_CH  per-channel write request
ch_address  in  NUM_CH x ADDR_W  per-channel address
ch_wdata  in  NUM_CH x DATA_W  per-channel write data
ch_rdata  out  DATA_W  read data, broadcast to all channels, qualified by ch_resp
ch_resp  out  NUM_CH  one-cycle completion pulse, one-hot
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_resp  in  1  memory completion
busy  out  1  transaction outstanding (state != IDLE)
grant_idx  out  clog2(NUM_CH), min 1  index of the current or last granted channel

Behaviour:
- Reset (rst low, async): state IDLE.
  - mem_read, mem_write, mem_address, mem_wdata, ch_rdata, ch_resp, busy, grant_idx all 0.
  - Round-robin pointer 0.
  - Reset mid-transaction abandons the transaction immediately; no ch_resp is issued.
- Channel protocol: a request is held stable (op, address, wdata) until that channel sees ch_resp, then dropped within one cycle.
  - ch_read and ch_write both high on one channel is illegal; the arbiter services it as a write.
- FSM IDLE -> BUSY -> RESP -> IDLE; all memory-side outputs registered.
- IDLE:
  - Pending set = ch_read | ch_write.
  - If non-empty: choose winner, latch op/address/wdata into mem_* at the clock edge, set grant_idx, go to BUSY.
  - Latency: request first seen at edge t gives mem_read/mem_write high from cycle t+1.
- Winner selection:
  - RR_MODE=1: first pending index at or after the pointer, wrapping modulo NUM_CH; on grant, pointer <= (winner+1) mod NUM_CH.
  - RR_MODE=0: lowest pending index wins; pointer unused.
- BUSY:
  - mem_* held constant until mem_resp.
  - At the edge where mem_resp=1: mem_read/mem_write <= 0; ch_rdata <= mem_rdata (read op only, otherwise unchanged); ch_resp[grant_idx] <= 1; go to RESP.
- RESP:
  - ch_resp high for exactly this cycle, cleared at the next edge; go to IDLE unconditionally.
  - Requests are not sampled during RESP, so a just-completed channel is never re-granted on a stale request.
- Back-to-back: minimum 3 cycles per transaction with single-cycle memory.
  - Two channels requesting continuously under RR alternate grants 0,1,0,1...
- NUM_CH=1: pointer constant 0, grant_idx constant 0.
- mem_resp in IDLE or RESP is ignored.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, BUSY, RESP};
  - arbitration mode constants ARB_RR=1, ARB_FIXED=0;
  - an index-width helper function.
- One combinational sub-module, arb_picker: inputs pending[NUM_CH], pointer, mode; outputs valid and winner index.
  - Unit-tested separately, including the wrap-around search.

Test Plan:
- Single read: ch_read[1]=1, ch_address[1]=0x0000_1040; memory returns 0xDEAD_BEEF_0123_4567 after 4 cycles -> mem_read high from t+1 with mem_address=0x1040; ch_rdata=0xDEADBEEF01234567 with ch_resp=2'b10 for exactly one cycle.
- Single write: ch_write[0]=1, ch_wdata[0]=0x1122_3344_5566_7788 -> mem_write=1 with that data; ch_resp[0] pulses once; ch_rdata unchanged.
- RR fairness: NUM_CH=4, RR_MODE=1, all channels requesting continuously -> grant order 0,1,2,3,0; each transaction 3 cycles with 1-cycle mem_resp.
- Fixed priority: RR_MODE=0, channels 0 and 2 requesting continuously -> channel 0 granted every transaction; channel 2 granted only after channel 0 drops.
- Reset mid-transaction: assert rst low during BUSY -> all outputs 0 asynchronously, no ch_resp; after release, the first request is granted with the pointer back at 0.
- Illegal read+write on channel 1 -> serviced as a write (mem_write=1, mem_read=0); single ch_resp pulse.
